// File: rtl/oci_dct_capture_ctrl.sv
// Nios II OCI debug-capture trace (DCT) sequencer: packs ITEM_W-bit trace items LSB-first into a 30-bit frame and hands frames to the consumer.
// Latency: frame_valid rises one cycle after the DEPTH-th accept (or the test_ending / timeout decision); outputs are registered except item_ready.
// Backpressure: item_ready is low while a frame is offered (EMIT) and after capture has ended; a frame is held stable until frame_ready.
// Optional idle-timeout flush of partial frames is compiled in with `define OCI_DCT_TIMEOUT_EN.
module oci_dct_capture_ctrl #(
    parameter int ITEM_W  = 2,
    parameter int DEPTH   = 15,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              item_valid,
    input  logic [ITEM_W-1:0] item_data,
    output logic              item_ready,
    output logic [29:0]       dct_buffer,
    output logic [3:0]        dct_count,
    output logic              frame_valid,
    input  logic              frame_ready,
    input  logic              test_ending,
    output logic              test_has_ended
);

    typedef enum logic [1:0] {
        S_CAPTURE = 2'd0,
        S_EMIT    = 2'd1,
        S_ENDED   = 2'd2
    } state_t;

    // Frame geometry must exactly fill the 30-bit buffer and fit the 4-bit count.
    generate
        if ((ITEM_W * DEPTH != 30) || (DEPTH > 15) || (TIMEOUT < 2) || (TIMEOUT > 128)) begin : g_param_check
            $error("oci_dct_capture_ctrl: illegal ITEM_W/DEPTH/TIMEOUT combination");
        end
    endgenerate

    state_t      r_state;
    state_t      w_next;
    logic [29:0] r_buf;
    logic [3:0]  r_cnt;
    logic        r_fv;
    logic        r_ended;
    logic        r_pending;

    logic        w_acc;
    logic [3:0]  w_cnt_post;
    logic        w_full;
    logic        w_timeout;

    // An item is taken only while capturing; the count after this cycle's accept drives the flush decisions.
    assign w_acc      = (r_state == S_CAPTURE) && item_valid;
    assign w_cnt_post = r_cnt + {3'b000, w_acc};
    assign w_full     = w_acc && (w_cnt_post == 4'(DEPTH));

`ifdef OCI_DCT_TIMEOUT_EN
    logic [6:0] r_idle;
    logic       w_idle_run;

    // Idle counting only matters while a partial frame is sitting in the buffer.
    assign w_idle_run = (r_state == S_CAPTURE) && (r_cnt != 4'd0) && !w_acc;
    assign w_timeout  = w_idle_run && (r_idle == 7'(TIMEOUT - 1));

    // Idle counter: advances on idle cycles, clears on accept, on timeout and outside CAPTURE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idle <= 7'd0;
        end else if (w_idle_run && !w_timeout) begin
            r_idle <= r_idle + 7'd1;
        end else begin
            r_idle <= 7'd0;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_CAPTURE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: full frame beats test_ending beats timeout; ENDED is absorbing until reset.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_CAPTURE: begin
                if (w_full) begin
                    w_next = S_EMIT;
                end else if (test_ending) begin
                    w_next = (w_cnt_post != 4'd0) ? S_EMIT : S_ENDED;
                end else if (w_timeout) begin
                    w_next = S_EMIT;
                end
            end
            S_EMIT: begin
                if (frame_ready) begin
                    w_next = (r_pending || test_ending) ? S_ENDED : S_CAPTURE;
                end
            end
            S_ENDED: w_next = S_ENDED;
            default: w_next = S_CAPTURE;
        endcase
    end

    // item_ready is the only combinational output and depends on state alone.
    always_comb begin
        item_ready = (r_state == S_CAPTURE);
    end

    // Frame datapath and registered status outputs; handshake clears the buffer so partial frames are zero-padded.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_buf     <= 30'd0;
            r_cnt     <= 4'd0;
            r_fv      <= 1'b0;
            r_ended   <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            r_fv    <= (w_next == S_EMIT);
            r_ended <= (w_next == S_ENDED);
            if (w_acc) begin
                r_buf[ITEM_W*int'(r_cnt) +: ITEM_W] <= item_data;
                r_cnt                               <= w_cnt_post;
            end
            if ((r_state == S_CAPTURE) && test_ending) begin
                r_pending <= 1'b1;
            end
            if ((r_state == S_EMIT) && frame_ready) begin
                r_buf <= 30'd0;
                r_cnt <= 4'd0;
            end
        end
    end

    assign dct_buffer     = r_buf;
    assign dct_count      = r_cnt;
    assign frame_valid    = r_fv;
    assign test_has_ended = r_ended;

endmodule
